// File: rtl/fifo_frame_tx.sv
// fifo_frame_tx: pops payload bytes from an upstream FIFO and emits framed
// packets on a valid/ready byte stream. Each frame is a 0xA5 header (sof),
// an 8-bit sequence number, payload_len payload bytes, and a modulo-256
// checksum of the payload (eof).
module fifo_frame_tx #(
  parameter int payload_len = 4,
  parameter int fifo_width  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [fifo_width-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  output logic [fifo_width-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sof,
  output logic                  tx_eof,
  output logic [7:0]            frame_cnt,
  output logic                  busy
);

  localparam logic [fifo_width-1:0] SOF_BYTE = fifo_width'(8'hA5);
  localparam logic [7:0]            LAST_IDX = 8'(payload_len - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEQ,
    PAYLOAD,
    CSUM
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [fifo_width-1:0] seq;
  logic [fifo_width-1:0] csum;
  logic [7:0]            byte_cnt;

  // The output register can take a new byte when it is empty or its current
  // byte is being accepted on this edge.
  logic                  out_free;

  logic                  load_byte;
  logic [fifo_width-1:0] load_val;
  logic                  load_sof;
  logic                  load_eof;
  logic                  clr_cnt;
  logic                  acc;
  logic                  frame_done;

  assign out_free = !tx_valid || tx_ready;
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the load/pop/accumulate controls for this edge.
  always_comb begin
    state_next = state;
    fifo_read  = 1'b0;
    load_byte  = 1'b0;
    load_val   = '0;
    load_sof   = 1'b0;
    load_eof   = 1'b0;
    clr_cnt    = 1'b0;
    acc        = 1'b0;
    frame_done = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty && out_free) begin
          state_next = HDR;
          load_byte  = 1'b1;
          load_val   = SOF_BYTE;
          load_sof   = 1'b1;
        end
      end

      HDR: begin
        if (out_free) begin
          state_next = SEQ;
          load_byte  = 1'b1;
          load_val   = seq;
        end
      end

      // Leaving SEQ loads nothing, which is the one bubble inside a frame.
      SEQ: begin
        if (out_free) begin
          state_next = PAYLOAD;
          clr_cnt    = 1'b1;
        end
      end

      PAYLOAD: begin
        if (out_free && !fifo_empty) begin
          fifo_read = 1'b1;
          load_byte = 1'b1;
          load_val  = fifo_data_out;
          acc       = 1'b1;
          if (byte_cnt == LAST_IDX) begin
            state_next = CSUM;
          end
        end
      end

      // tx_eof on a valid byte means the checksum is already loaded and only
      // its acceptance is awaited; otherwise the last payload byte is still
      // draining and the checksum goes in on the first free edge.
      CSUM: begin
        if (tx_valid && tx_eof) begin
          if (tx_ready) begin
            frame_done = 1'b1;
            state_next = IDLE;
          end
        end else if (out_free) begin
          load_byte = 1'b1;
          load_val  = csum;
          load_eof  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output byte register: load a new byte, or empty it once accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_sof   <= 1'b0;
      tx_eof   <= 1'b0;
    end else if (load_byte) begin
      tx_data  <= load_val;
      tx_valid <= 1'b1;
      tx_sof   <= load_sof;
      tx_eof   <= load_eof;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
      tx_sof   <= 1'b0;
      tx_eof   <= 1'b0;
    end
  end

  // Payload byte counter, running checksum, sequence number and frame count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt  <= '0;
      csum      <= '0;
      seq       <= '0;
      frame_cnt <= '0;
    end else begin
      if (clr_cnt) begin
        byte_cnt <= '0;
      end else if (acc) begin
        byte_cnt <= byte_cnt + 8'd1;
      end

      if (acc) begin
        csum <= csum + fifo_data_out;
      end else if (frame_done) begin
        csum <= '0;
      end

      if (frame_done) begin
        frame_cnt <= frame_cnt + 8'd1;
        seq       <= seq + 1'b1;
      end
    end
  end

  // A pop must only happen with data present and room in the output register.
  a_read_legal : assert property (@(posedge clk) disable iff (!rstn)
    fifo_read |-> (!fifo_empty && (!tx_valid || tx_ready)));

  // A stalled byte and its markers hold until accepted.
  a_stall_stable : assert property (@(posedge clk) disable iff (!rstn)
    (tx_valid && !tx_ready) |=>
      (tx_valid && $stable(tx_data) && $stable(tx_sof) && $stable(tx_eof)));

endmodule

// File: tb/tb_fifo_frame_tx.sv
// tb_fifo_frame_tx: scoreboard bench for fifo_frame_tx. A queue-based model
// turns every byte written into the source FIFO into the expected framed
// output stream; a monitor pops and compares on each accepted byte.
module tb_fifo_frame_tx;

  localparam int P = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic [7:0] fifo_data_out;
  logic       fifo_empty;
  logic       fifo_read;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_sof;
  logic       tx_eof;
  logic [7:0] frame_cnt;
  logic       busy;

  fifo_frame_tx #(
    .payload_len (P),
    .fifo_width  (8)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_read     (fifo_read),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_sof        (tx_sof),
    .tx_eof        (tx_eof),
    .frame_cnt     (frame_cnt),
    .busy          (busy)
  );

  int         vectors     = 0;
  int         miscompares = 0;

  logic [7:0] src_q[$];
  exp_t       exp_q[$];
  int         model_cnt    = 0;
  int         model_sum    = 0;
  int         model_seq    = 0;
  int         model_frames = 0;

  int         pop_cnt      = 0;
  int         cyc          = 0;
  int         sof_cyc      = 0;
  bit         tp_check     = 0;
  bit         cnt_pending  = 0;
  bit         hold_pending = 0;
  exp_t       held;
  int         ready_mode   = 0;
  int         phase        = 0;
  logic       do_pop;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic void driveFifo();
    fifo_empty    = (src_q.size() == 0);
    fifo_data_out = (src_q.size() == 0) ? 8'h00 : src_q[0];
  endfunction

  // Reference model: each payload byte extends the expected stream; the first
  // byte of a frame brings its header and sequence number, the last its sum.
  function automatic void modelByte(input logic [7:0] b);
    if (model_cnt == 0) begin
      exp_q.push_back('{8'hA5, 1'b1, 1'b0});
      exp_q.push_back('{8'(model_seq), 1'b0, 1'b0});
      model_sum = 0;
    end
    exp_q.push_back('{b, 1'b0, 1'b0});
    model_sum += int'(b);
    model_cnt++;
    if (model_cnt == P) begin
      exp_q.push_back('{8'(model_sum % 256), 1'b0, 1'b1});
      model_cnt = 0;
      model_seq = (model_seq + 1) % 256;
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    src_q.push_back(b);
    driveFifo();
    modelByte(b);
  endtask

  // Upstream FIFO: a pop seen at the edge takes effect just after it.
  always @(posedge clk) begin
    do_pop = fifo_read;
    #1;
    if (do_pop) begin
      if (src_q.size() != 0) void'(src_q.pop_front());
      pop_cnt++;
    end
    driveFifo();
  end

  // Downstream ready generator for the patterned and random phases.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) begin
      tx_ready = (phase == 0);
      phase    = (phase + 1) % 3;
    end else if (ready_mode == 2) begin
      tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every accepted byte with the scoreboard head, checks
  // stall stability, pop legality and the frame counter.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (cnt_pending) begin
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(model_frames % 256));
        cnt_pending = 0;
      end
      if (fifo_empty) checkOutput("read_while_empty", 32'(fifo_read), 32'd0);
      if (tx_valid && !tx_ready)
        checkOutput("read_while_stalled", 32'(fifo_read), 32'd0);
      if (hold_pending) begin
        checkOutput("stall_valid", 32'(tx_valid), 32'd1);
        checkOutput("stall_data", 32'(tx_data), 32'(held.d));
        checkOutput("stall_sof", 32'(tx_sof), 32'(held.sof));
        checkOutput("stall_eof", 32'(tx_eof), 32'(held.eof));
        hold_pending = 0;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no output",
                   tx_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("tx_data", 32'(tx_data), 32'(e.d));
          checkOutput("tx_sof", 32'(tx_sof), 32'(e.sof));
          checkOutput("tx_eof", 32'(tx_eof), 32'(e.eof));
          if (e.sof) sof_cyc = cyc;
          if (e.eof) begin
            model_frames++;
            cnt_pending = 1;
            if (tp_check) checkOutput("throughput", 32'(cyc - sof_cyc), 32'(P + 3));
          end
        end
      end else if (tx_valid) begin
        hold_pending = 1;
        held         = '{tx_data, tx_sof, tx_eof};
      end
    end
  end

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL timeout_%s: %0d bytes outstanding, expected 0",
               name, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Asynchronous reset between edges; the model restarts from whatever the
  // FIFO still holds, since bytes already popped are gone.
  task automatic pulseReset();
    @(posedge clk);
    #4;
    rstn = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_data", 32'(tx_data), 32'd0);
    checkOutput("rst_sof_eof", 32'({tx_sof, tx_eof}), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_read", 32'(fifo_read), 32'd0);
    exp_q.delete();
    model_cnt    = 0;
    model_seq    = 0;
    model_frames = 0;
    cnt_pending  = 0;
    hold_pending = 0;
    foreach (src_q[i]) modelByte(src_q[i]);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_read_hold", 32'(fifo_read), 32'd0);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int base;
    rstn     = 1'b0;
    tx_ready = 1'b0;
    driveFifo();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("init_valid", 32'(tx_valid), 32'd0);
    checkOutput("init_data", 32'(tx_data), 32'd0);
    checkOutput("init_busy", 32'(busy), 32'd0);
    checkOutput("init_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("init_read", 32'(fifo_read), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #2;

    // Basic frame with a permanently ready sink, including cycle count.
    $display("[TB] basic frame 11 22 33 44");
    tx_ready = 1'b1;
    tp_check = 1;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    waitDrain("basic", 100);
    tp_check = 0;

    // Same data under a 1,0,0 ready pattern; exactly P pops expected.
    $display("[TB] stalling sink");
    base       = pop_cnt;
    phase      = 0;
    ready_mode = 1;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    waitDrain("stall", 200);
    checkOutput("stall_pops", 32'(pop_cnt - base), 32'(P));
    ready_mode = 0;
    tx_ready   = 1'b1;

    // FIFO runs dry mid-payload, refilled 20 cycles later.
    $display("[TB] mid-payload underflow");
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    repeat (20) @(posedge clk);
    #2;
    checkOutput("underflow_busy", 32'(busy), 32'd1);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    waitDrain("underflow", 100);

    // Checksum carry discard.
    $display("[TB] checksum wrap");
    for (int i = 0; i < P; i++) applyStimulus(8'hFF);
    waitDrain("csum_wrap", 100);

    // Random data, random gaps, random ready.
    $display("[TB] random traffic");
    ready_mode = 2;
    for (int i = 0; i < 30 * P; i++) begin
      applyStimulus(8'($urandom_range(0, 255)));
      @(posedge clk);
      #2;
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #2;
      end
    end
    waitDrain("random", 3000);
    ready_mode = 0;
    tx_ready   = 1'b1;

    // Reset while the second payload byte is pending.
    $display("[TB] reset mid-frame");
    base = pop_cnt;
    for (int i = 0; i < 2 * P; i++) applyStimulus(8'(8'h50 + i));
    for (int n = 0; n < 50 && (pop_cnt - base) < 2; n++) begin
      @(posedge clk);
      #2;
    end
    tx_ready = 1'b0;
    pulseReset();
    tx_ready = 1'b1;
    applyStimulus(8'h61);
    applyStimulus(8'h62);
    waitDrain("after_reset", 200);

    // 257 frames from reset: sequence and frame counter wrap.
    $display("[TB] sequence wrap");
    pulseReset();
    tx_ready = 1'b1;
    for (int i = 0; i < 257 * P; i++) applyStimulus(8'($urandom_range(0, 255)));
    waitDrain("seq_wrap", 5000);
    checkOutput("wrap_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_frame_tx.md
FIFO_FRAME_TX -- requirements
Module: fifo_frame_tx

Interface
REQ-001 Parameter: payload_len, default 4, payload bytes per frame; legal range 1..255.
REQ-002 Parameter: fifo_width, default 8, byte width; only 8 is supported.
REQ-003 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port: rstn, input, 1, asynchronous active-low reset.
REQ-005 Port: fifo_data_out, input, 8, head-of-FIFO data; combinationally valid whenever fifo_empty=0.
REQ-006 Port: fifo_empty, input, 1, upstream FIFO empty flag.
REQ-007 Port: fifo_read, output, 1, single-cycle pop strobe to the upstream FIFO.
REQ-008 Port: tx_data, output, 8, registered frame byte.
REQ-009 Port: tx_valid, output, 1, tx_data holds a byte not yet accepted.
REQ-010 Port: tx_ready, input, 1, downstream accepts the byte on an edge where tx_valid=1 and tx_ready=1.
REQ-011 Port: tx_sof, output, 1, marks the header byte; qualified by tx_valid.
REQ-012 Port: tx_eof, output, 1, marks the checksum byte; qualified by tx_valid.
REQ-013 Port: frame_cnt, output, 8, count of completed frames; wraps from 255 to 0.
REQ-014 Port: busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-015 Frame format: 0xA5 (sof), seq, payload_len payload bytes, checksum (eof); total payload_len+3 bytes.
REQ-016 seq: 8-bit frame sequence number; 0 after reset; increments by 1 per completed frame; wraps 255->0.
REQ-017 Checksum: modulo-256 sum of the payload bytes only; carries are discarded.
REQ-018 FSM states: IDLE, HDR, SEQ, PAYLOAD, CSUM.
REQ-019 Output register is "free" when tx_valid=0, or when tx_valid=1 and tx_ready=1.
REQ-020 Transition IDLE->HDR occurs on an edge where fifo_empty=0 and the output register is free; that edge loads tx_data=0xA5, tx_sof=1, tx_valid=1.
REQ-021 Transition HDR->SEQ occurs on the first free edge and loads seq.
REQ-022 Transition SEQ->PAYLOAD occurs on the first free edge and loads no byte; the PAYLOAD byte counter is cleared to 0.
REQ-023 In PAYLOAD, fifo_read=1 combinationally iff the output register is free and fifo_empty=0; on that edge, fifo_data_out loads into tx_data, the checksum accumulates, and the byte counter increments.
REQ-024 fifo_read shall never be 1 while fifo_empty=1 or while tx_valid=1 and tx_ready=0.
REQ-025 If the FIFO is empty mid-payload, the FSM stalls in PAYLOAD with no timeout; tx_valid drops once the pending byte is accepted.
REQ-026 After the byte with counter value payload_len-1 is loaded, the FSM moves to CSUM.
REQ-027 In CSUM, the first free edge loads the checksum with tx_eof=1.
REQ-028 When the checksum byte is accepted: frame_cnt+1, seq+1, checksum register cleared, state->IDLE.
REQ-029 While tx_valid=1 and tx_ready=0, tx_data, tx_sof and tx_eof shall stay stable.
REQ-030 With tx_ready held at 1 and the FIFO never empty, throughput is 1 byte per cycle, except for one bubble cycle at the SEQ->PAYLOAD transition.
REQ-031 Back-to-back frames: after CSUM acceptance, IDLE re-enters HDR on the next edge if fifo_empty=0.
REQ-032 tx_sof and tx_eof are 0 on every non-header and non-checksum byte respectively.

Reset
REQ-033 rstn=0 asynchronously forces: state=IDLE, tx_valid=0, tx_data=0, tx_sof=0, tx_eof=0, frame_cnt=0, seq=0, checksum=0, byte counter=0, busy=0.
REQ-034 fifo_read shall be 0 throughout reset.
REQ-035 Reset mid-frame discards the partial frame; bytes already popped are lost and are not re-read.
REQ-036 The first frame after reset carries seq=0.

Verification
REQ-037 FIFO holds 11,22,33,44 and tx_ready=1 -> output sequence A5,00,11,22,33,44,AA; sof on A5, eof on AA; frame_cnt=1.
REQ-038 Same data with tx_ready toggling 1,0,0,1,... -> identical byte sequence, no byte duplicated or dropped, tx_data stable during every stall, exactly 4 fifo_read pulses.
REQ-039 FIFO holds 01,02 only, with 03,04 written 20 cycles later -> PAYLOAD stalls, fifo_read stays 0 while empty, then the frame completes with checksum 0A.
REQ-040 Payload FF,FF,FF,FF -> checksum FC.
REQ-041 256 consecutive frames -> seq runs 00..FF then frame 257 carries seq=00; frame_cnt wraps to 0 after 256 frames.
REQ-042 rstn pulsed low while the second payload byte is pending -> tx_valid=0 immediately (asynchronously); the next frame starts with A5,00 using the remaining FIFO data.
